// File: rtl/mem_request_queue_if.sv
// mem_request_queue_if: CPU request/response and memory-subsystem signals of the request queue
interface mem_request_queue_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic        rsp_valid;
   logic        rsp_store;
   logic        rsp_err;
   logic [31:0] rsp_data;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_load;
   logic        mem_store;
   logic [31:0] mem_rdata;
   logic        mem_done;
   modport slave (
      input  req_valid, req_store, req_addr, req_data, mem_rdata, mem_done,
      output req_ready, rsp_valid, rsp_store, rsp_err, rsp_data,
             mem_addr, mem_wdata, mem_load, mem_store
   );
   modport master (
      output req_valid, req_store, req_addr, req_data, mem_rdata, mem_done,
      input  req_ready, rsp_valid, rsp_store, rsp_err, rsp_data,
             mem_addr, mem_wdata, mem_load, mem_store
   );
endinterface

// File: rtl/mem_request_queue.sv
// mem_request_queue: in-order FIFO of load/store requests issued one at a time with a completion watchdog
module mem_request_queue #(
   parameter int DEPTH      = 4,
   parameter int WAIT_LIMIT = 64
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   mem_request_queue_if.slave       q_if,
   output logic                     busy_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int WW = $clog2(WAIT_LIMIT + 1);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
   typedef struct packed {
      logic        store;
      logic [31:0] addr;
      logic [31:0] data;
   } entry_t;
   entry_t        fifo_q [DEPTH];
   state_e        state_q, state_d;
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [WW-1:0] wcnt_q, wcnt_d;
   logic          cur_store_q, cur_store_d;
   logic [31:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
   logic          rsp_store_q, rsp_store_d, rsp_err_q, rsp_err_d;
   logic [31:0]   rsp_data_q, rsp_data_d;
   logic          push, pop, done, tmo, strobe;
   assign q_if.req_ready = cnt_q != (AW+1)'(DEPTH);
   assign push   = q_if.req_valid && q_if.req_ready;
   assign done   = state_q == WAIT && q_if.mem_done;
   // completion in the final wait cycle takes priority over the timeout
   assign tmo    = state_q == WAIT && !q_if.mem_done && wcnt_q == WW'(WAIT_LIMIT);
   assign pop    = done || tmo;
   assign strobe = state_q == ISSUE || state_q == WAIT;
   always_comb begin
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      cur_store_d = cur_store_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rsp_store_d = rsp_store_q;
      rsp_err_d   = rsp_err_q;
      rsp_data_d  = rsp_data_q;
      wr_d        = wr_q + AW'(push);
      rd_d        = rd_q + AW'(pop);
      cnt_d       = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      case (state_q)
         IDLE: if (cnt_q != '0) begin
            state_d     = ISSUE;
            cur_store_d = fifo_q[rd_q].store;
            mem_addr_d  = fifo_q[rd_q].addr;
            mem_wdata_d = fifo_q[rd_q].data;
         end
         ISSUE: begin
            state_d = WAIT;
            wcnt_d  = WW'(1);
         end
         WAIT: begin
            wcnt_d = wcnt_q + WW'(1);
            if (pop) begin
               state_d     = RESP;
               rsp_store_d = cur_store_q;
               rsp_err_d   = tmo;
               rsp_data_d  = done && !cur_store_q ? q_if.mem_rdata : '0;
            end
         end
         RESP: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         wr_q        <= '0;
         rd_q        <= '0;
         cnt_q       <= '0;
         wcnt_q      <= '0;
         cur_store_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rsp_store_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         cnt_q       <= cnt_d;
         wcnt_q      <= wcnt_d;
         cur_store_q <= cur_store_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rsp_store_q <= rsp_store_d;
         rsp_err_q   <= rsp_err_d;
         rsp_data_q  <= rsp_data_d;
      end
   end
   always_ff @(posedge clk_i) begin
      if (push) fifo_q[wr_q] <= {q_if.req_store, q_if.req_addr, q_if.req_data};
   end
   assign q_if.mem_load  = strobe && !cur_store_q;
   assign q_if.mem_store = strobe && cur_store_q;
   assign q_if.mem_addr  = mem_addr_q;
   assign q_if.mem_wdata = mem_wdata_q;
   assign q_if.rsp_valid = state_q == RESP;
   assign q_if.rsp_store = rsp_store_q;
   assign q_if.rsp_err   = rsp_err_q;
   assign q_if.rsp_data  = rsp_data_q;
   assign busy_o  = state_q != IDLE || cnt_q != '0;
   assign count_o = cnt_q;
endmodule

// File: tb/tb_mem_request_queue.sv
// tb_mem_request_queue: randomized self-checking bench with a memory responder and request-order model
module tb_mem_request_queue;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       busy;
   logic [2:0] count;
   mem_request_queue_if bus();
   mem_request_queue #(.DEPTH(4), .WAIT_LIMIT(64)) dut (
      .clk_i(clk), .rst_ni(rst_n), .q_if(bus), .busy_o(busy), .count_o(count)
   );
   always #5 clk = ~clk;
   typedef struct {logic store; logic [31:0] addr; logic [31:0] data;} req_t;
   typedef struct {logic store; logic err; logic [31:0] data; int c;} rsp_t;
   req_t        model_q[$];
   rsp_t        rsp_log[$];
   int          checks = 0, fails = 0, cyc = 0, acc_cyc = 0;
   int          mem_wait = 1, hi_cnt = 0;
   bit          manual = 1'b1, man_done = 1'b0, force_en = 1'b0, auto_done;
   logic [31:0] force_val = '0;
   function automatic logic [31:0] mfn(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h3C3C_A5A5;
   endfunction
   always @(posedge clk) cyc <= cyc + 1;
   // memory responder: completes mem_wait cycles into WAIT (never if negative), logs responses
   always @(negedge clk) begin
      hi_cnt = (bus.mem_load || bus.mem_store) ? hi_cnt + 1 : 0;
      auto_done = mem_wait >= 0 && hi_cnt >= mem_wait + 1;
      bus.mem_done = manual ? man_done : auto_done;
      bus.mem_rdata = force_en ? force_val : mfn(bus.mem_addr);
      if (bus.rsp_valid) rsp_log.push_back('{bus.rsp_store, bus.rsp_err, bus.rsp_data, cyc});
   end
   task automatic enq(input logic s, input logic [31:0] a, input logic [31:0] d);
      bit seen;
      bus.req_valid = 1'b1; bus.req_store = s; bus.req_addr = a; bus.req_data = d;
      for (int i = 0; i < 300; i++) begin
         seen = bus.req_ready;
         @(negedge clk);
         if (seen) begin
            acc_cyc = cyc;
            model_q.push_back('{s, a, d});
            bus.req_valid = 1'b0;
            return;
         end
      end
      bus.req_valid = 1'b0;
      checks++; fails++;
      $display("FAIL enq_timeout: request %h not accepted in 300 cycles", a);
   endtask
   task automatic wait_rsp(input int n, input int budget);
      for (int i = 0; i < budget && rsp_log.size() < n; i++) @(negedge clk);
      checks++;
      if (rsp_log.size() < n) begin
         fails++;
         $display("FAIL rsp_wait: got %0d responses, required %0d", rsp_log.size(), n);
      end
   endtask
   task automatic test_reset;
      rst_n = 1'b0; manual = 1'b1; man_done = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: %b required 1", bus.req_ready); end
      checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: %b required 0", busy); end
      checks++; if (count !== 3'd0) begin fails++; $display("FAIL rst_count: %0d required 0", count); end
      checks++; if ({bus.rsp_valid, bus.rsp_store, bus.rsp_err} !== 3'b000) begin fails++; $display("FAIL rst_rsp_flags: %b required 000", {bus.rsp_valid, bus.rsp_store, bus.rsp_err}); end
      checks++; if (bus.rsp_data !== 32'h0) begin fails++; $display("FAIL rst_rsp_data: %h required 0", bus.rsp_data); end
      checks++; if ({bus.mem_load, bus.mem_store} !== 2'b00) begin fails++; $display("FAIL rst_strobes: %b required 00", {bus.mem_load, bus.mem_store}); end
      checks++; if ({bus.mem_addr, bus.mem_wdata} !== 64'h0) begin fails++; $display("FAIL rst_mem_bus: %h required 0", {bus.mem_addr, bus.mem_wdata}); end
      rst_n = 1'b1; manual = 1'b0;
      @(negedge clk);
   endtask
   task automatic test_single_load;
      int n0, hi; bit addr_ok;
      rsp_log.delete(); model_q.delete();
      mem_wait = 1; force_en = 1'b1; force_val = 32'hDEADBEEF;
      enq(1'b0, 32'h40, 32'h0);
      n0 = acc_cyc; hi = 0; addr_ok = 1'b1;
      repeat (8) begin
         if (bus.mem_load) begin hi++; if (bus.mem_addr !== 32'h40) addr_ok = 1'b0; end
         @(negedge clk);
      end
      force_en = 1'b0;
      checks++; if (hi != 2) begin fails++; $display("FAIL load_strobe_len: %0d cycles required 2", hi); end
      checks++; if (!addr_ok) begin fails++; $display("FAIL load_addr: mem_addr %h required 00000040", bus.mem_addr); end
      checks++; if (rsp_log.size() != 1) begin fails++; $display("FAIL load_rsp_count: %0d required 1", rsp_log.size()); end
      if (rsp_log.size() >= 1) begin
         checks++; if (rsp_log[0].c - n0 != 3) begin fails++; $display("FAIL load_latency: %0d required 3", rsp_log[0].c - n0); end
         checks++; if (rsp_log[0].data !== 32'hDEADBEEF) begin fails++; $display("FAIL load_data: %h required deadbeef", rsp_log[0].data); end
         checks++; if ({rsp_log[0].store, rsp_log[0].err} !== 2'b00) begin fails++; $display("FAIL load_flags: %b required 00", {rsp_log[0].store, rsp_log[0].err}); end
      end
   endtask
   task automatic test_single_store;
      int n0, hi, stable;
      rsp_log.delete(); model_q.delete();
      mem_wait = 5;
      enq(1'b1, 32'h80, 32'h12345678);
      n0 = acc_cyc; hi = 0; stable = 0;
      repeat (14) begin
         if (bus.mem_store) hi++;
         if (bus.mem_store && bus.mem_addr === 32'h80 && bus.mem_wdata === 32'h12345678) stable++;
         @(negedge clk);
      end
      checks++; if (hi != 6) begin fails++; $display("FAIL store_strobe_len: %0d cycles required 6", hi); end
      checks++; if (stable != 6) begin fails++; $display("FAIL store_bus_stable: %0d cycles required 6", stable); end
      checks++; if (rsp_log.size() != 1) begin fails++; $display("FAIL store_rsp_count: %0d required 1", rsp_log.size()); end
      if (rsp_log.size() >= 1) begin
         checks++; if (rsp_log[0].c - n0 != 7) begin fails++; $display("FAIL store_latency: %0d required 7", rsp_log[0].c - n0); end
         checks++; if ({rsp_log[0].store, rsp_log[0].err, rsp_log[0].data} !== {2'b10, 32'h0}) begin fails++; $display("FAIL store_rsp: store %b err %b data %h required 1 0 0", rsp_log[0].store, rsp_log[0].err, rsp_log[0].data); end
      end
   endtask
   task automatic test_fill;
      int acc5;
      req_t e;
      rsp_log.delete(); model_q.delete();
      manual = 1'b1; man_done = 1'b0; mem_wait = 2;
      for (int i = 0; i < 4; i++) enq(i % 2 == 1, 32'h100 + 32'(i) * 4, $urandom);
      checks++; if (count !== 3'd4) begin fails++; $display("FAIL fill_count: %0d required 4", count); end
      checks++; if (bus.req_ready !== 1'b0) begin fails++; $display("FAIL fill_ready: %b required 0", bus.req_ready); end
      bus.req_valid = 1'b1; bus.req_store = 1'b0; bus.req_addr = 32'h200; bus.req_data = 32'h0;
      repeat (3) @(negedge clk);
      checks++; if (count !== 3'd4) begin fails++; $display("FAIL fill_no_accept: count %0d required 4", count); end
      manual = 1'b0;
      enq(1'b0, 32'h200, 32'h0);
      acc5 = acc_cyc;
      wait_rsp(5, 200);
      repeat (3) @(negedge clk);
      if (rsp_log.size() >= 1) begin
         checks++; if (acc5 != rsp_log[0].c + 1) begin fails++; $display("FAIL fill_accept_after_pop: accept cycle %0d required %0d", acc5, rsp_log[0].c + 1); end
      end
      foreach (rsp_log[i]) begin
         e = model_q.pop_front();
         checks++;
         if (rsp_log[i].store !== e.store || rsp_log[i].err !== 1'b0 || rsp_log[i].data !== (e.store ? 32'h0 : mfn(e.addr))) begin
            fails++;
            $display("FAIL fill_rsp%0d: store %b err %b data %h required %b 0 %h", i, rsp_log[i].store, rsp_log[i].err, rsp_log[i].data, e.store, e.store ? 32'h0 : mfn(e.addr));
         end
      end
      checks++; if (count !== 3'd0 || busy !== 1'b0) begin fails++; $display("FAIL fill_drain: count %0d busy %b required 0 0", count, busy); end
   endtask
   task automatic test_wrap;
      req_t e;
      rsp_log.delete(); model_q.delete();
      mem_wait = 2;
      for (int i = 0; i < 10; i++) enq(i % 2 == 1, $urandom & 32'hFFFF_FFFC, $urandom);
      wait_rsp(10, 400);
      repeat (3) @(negedge clk);
      checks++; if (rsp_log.size() != 10) begin fails++; $display("FAIL wrap_rsp_count: %0d required 10", rsp_log.size()); end
      foreach (rsp_log[i]) begin
         e = model_q.pop_front();
         checks++;
         if (rsp_log[i].store !== e.store || rsp_log[i].err !== 1'b0 || rsp_log[i].data !== (e.store ? 32'h0 : mfn(e.addr))) begin
            fails++;
            $display("FAIL wrap_rsp%0d: store %b err %b data %h required %b 0 %h", i, rsp_log[i].store, rsp_log[i].err, rsp_log[i].data, e.store, e.store ? 32'h0 : mfn(e.addr));
         end
      end
      checks++; if (count !== 3'd0 || busy !== 1'b0) begin fails++; $display("FAIL wrap_drain: count %0d busy %b required 0 0", count, busy); end
   endtask
   task automatic test_timeout;
      int n0;
      rsp_log.delete(); model_q.delete();
      mem_wait = -1;
      enq(1'b0, 32'h300, 32'h0);
      n0 = acc_cyc;
      enq(1'b1, 32'h304, 32'hCAFE0001);
      enq(1'b0, 32'h308, 32'h0);
      for (int i = 0; i < 120; i++) begin
         if (rsp_log.size() >= 1) break;
         @(negedge clk);
      end
      mem_wait = 64;
      wait_rsp(3, 400);
      if (rsp_log.size() >= 3) begin
         checks++; if (rsp_log[0].c - n0 != 66) begin fails++; $display("FAIL tmo_latency: %0d required 66", rsp_log[0].c - n0); end
         checks++; if ({rsp_log[0].store, rsp_log[0].err, rsp_log[0].data} !== {2'b01, 32'h0}) begin fails++; $display("FAIL tmo_rsp: store %b err %b data %h required 0 1 0", rsp_log[0].store, rsp_log[0].err, rsp_log[0].data); end
         checks++; if ({rsp_log[1].store, rsp_log[1].err, rsp_log[1].data} !== {2'b10, 32'h0}) begin fails++; $display("FAIL tmo_limit_done_store: store %b err %b data %h required 1 0 0", rsp_log[1].store, rsp_log[1].err, rsp_log[1].data); end
         checks++; if ({rsp_log[2].store, rsp_log[2].err, rsp_log[2].data} !== {2'b00, mfn(32'h308)}) begin fails++; $display("FAIL tmo_limit_done_load: store %b err %b data %h required 0 0 %h", rsp_log[2].store, rsp_log[2].err, rsp_log[2].data, mfn(32'h308)); end
      end
   endtask
   task automatic test_reset_mid_wait;
      int bad;
      rsp_log.delete(); model_q.delete();
      manual = 1'b1; man_done = 1'b0;
      enq(1'b0, 32'h400, 32'h0);
      enq(1'b1, 32'h404, 32'h5);
      repeat (3) @(negedge clk);
      checks++; if (bus.mem_load !== 1'b1) begin fails++; $display("FAIL rmw_in_wait: mem_load %b required 1", bus.mem_load); end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; man_done = 1'b1;
      checks++; if ({bus.mem_load, bus.mem_store} !== 2'b00) begin fails++; $display("FAIL rmw_strobes: %b required 00", {bus.mem_load, bus.mem_store}); end
      checks++; if (count !== 3'd0 || busy !== 1'b0 || bus.req_ready !== 1'b1) begin fails++; $display("FAIL rmw_flush: count %0d busy %b ready %b required 0 0 1", count, busy, bus.req_ready); end
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         if (bus.rsp_valid || bus.mem_load || bus.mem_store || busy) bad++;
      end
      man_done = 1'b0;
      checks++; if (bad != 0) begin fails++; $display("FAIL rmw_quiet: %0d active cycles required 0", bad); end
      checks++; if (rsp_log.size() != 0) begin fails++; $display("FAIL rmw_no_rsp: %0d responses required 0", rsp_log.size()); end
      manual = 1'b0;
   endtask
   initial begin
      bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_addr = '0; bus.req_data = '0;
      test_reset();
      test_single_load();
      test_single_store();
      test_fill();
      test_wrap();
      test_timeout();
      test_reset_mid_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
